u409_ta_engine: RTL
===================

Name: u409_ta_engine

Overview:
- Parametrised transfer-acknowledge engine for the 68040 local bus at 40 MHz.
- Decodes up to NUM_REGIONS address windows with a priority decoder and latches each transfer start.
- Generates nTA after per-region wait states, supporting externally paced regions and 4-beat line bursts.
- Drives per-region nTCI/nTBI; successor to the fixed ROM/CIA acknowledge logic in U409.

Parameters:
- NUM_REGIONS, 4: number of decoded windows, 1..8; index 0 has the highest priority.
- REGION_BASE, {NUM_REGIONS{20'h0}}: packed 20-bit bases compared against A[31:12].
- REGION_MASK, {NUM_REGIONS{20'hFFFFF}}: packed 20-bit masks; 1 = bit compared.
- REGION_WAIT, {NUM_REGIONS{4'd2}}: packed first-beat wait states, 0..15.
- REGION_FLAGS, {NUM_REGIONS{4'b0110}}: packed per region, bit3 EXT, bit2 TCI, bit1 TBI, bit0 BURST_OK.
- BURST_WAIT, 1: wait states before beats 2..4, 0..15.
- OVL_REGION, 0: region forced on a hit for A[31:19]==0 while OVL=1.
- TIMEOUT_CYCLES, 255: EXT-wait limit; used only with the optional feature.

Ports:
- CLK40  in  1  bus clock, 40 MHz.
- TS_RESET  in  1  reset, asynchronous, active-high.
- nTS  in  1  68040 transfer start, active low, one-clock pulse.
- A  in  20  A[31:12].
- SIZ  in  2  transfer size; 2'b11 = line.
- RnW  in  1  read/not-write; latched, reported only.
- OVL  in  1  ROM overlay.
- EXT_ACK  in  1  synchronous ready from a paced agent (CIA/E-clock), active high.
- nTA_OUT  out  1  transfer acknowledge value.
- TA_OE  out  1  output enable for the nTA pin.
- nTCI  out  1  cache inhibit, valid while nTA_OUT=0.
- nTBI  out  1  burst inhibit, valid while nTA_OUT=0.
- nTEA  out  1  transfer error acknowledge.
- HIT  out  NUM_REGIONS  one-hot latched region, held for the whole transfer.
- BUSY  out  1  state != IDLE.

Behaviour:
- Reset (TS_RESET high, immediate): state IDLE.
  - nTA_OUT=1, TA_OE=0, nTCI=1, nTBI=1, nTEA=1, HIT=0, BUSY=0.
  - Counters and pending flag cleared.
- States: IDLE, DECODE, WAIT, EXTW, ACK, NEGATE.
- IDLE: on nTS=0 at edge E0 (or pending flag set), latch A, SIZ, RnW, OVL and go to DECODE.
- DECODE (edge E1):
  - hit_i = ((A ^ BASE_i) & MASK_i) == 0; the lowest index wins.
  - OVL=1 and A[31:19]==0 forces OVL_REGION.
  - No hit: return to IDLE with nothing driven.
  - Hit: HIT set, wait counter loaded with REGION_WAIT, state WAIT.
- WAIT: decrement each clock; at 0, go to EXTW if EXT, else ACK.
  - Wait=0 gives nTA_OUT=0 in the cycle after edge E2; latency = 2 + wait clocks.
- EXTW: hold until EXT_ACK=1 is sampled, then ACK.
- ACK: exactly one clock with nTA_OUT=0 and TA_OE=1.
  - nTCI = !TCI and nTBI = !TBI (TBI forced when BURST_OK=0).
- Burst: BURST_OK=1, TBI=0 and SIZ=11 give 4 beats.
  - 2-bit beat counter; beats 2..4 each preceded by BURST_WAIT clocks in WAIT, with no EXT wait.
  - Wrap from 3 to 0 ends the transfer.
  - Any other case gives a single beat.
- NEGATE: after the last beat, one clock with nTA_OUT=1 and TA_OE=1, then TA_OE=0, HIT=0, IDLE.
- nTS=0 while BUSY sets the pending flag.
  - Serviced directly from NEGATE into DECODE; never dropped.
  - A second nTS while pending is already set is ignored.
- TS_RESET mid-transfer aborts at once; the nTA pin is released the same instant.

Optional Feature:
- Macro TA_TIMEOUT_EN.
- Defined: an 8-bit counter runs in EXTW.
  - Reaching TIMEOUT_CYCLES gives one clock of nTEA=0 with TA_OE=1 and nTA_OUT=1, then NEGATE.
  - EXT_ACK and the timeout in the same clock: EXT_ACK wins.
- Undefined: nTEA is tied 1 and EXTW waits indefinitely.

Decomposition:
- Shared package u409_pkg holds:
  - state enum;
  - field widths ADDR_W=20, WAIT_W=4;
  - flag bit indices FLAG_EXT, FLAG_TCI, FLAG_TBI, FLAG_BURST;
  - SIZ_LINE=2'b11.
- One natural sub-module: u409_region_decode, a combinational priority/OVL decoder returning a one-hot HIT and the selected region index.

Test Plan:
- Region0 base 20'h00F80, mask 20'hFFF80, wait 2, TCI set; nTS pulse with A=20'h00F80 -> nTA_OUT=0 for exactly one clock, 4 clocks after the nTS edge; nTCI=0; nTBI=0; HIT=4'b0001.
- Region1 BURST_OK, TBI=0, wait 1, BURST_WAIT 1; nTS with SIZ=11 -> four nTA pulses at offsets 3, 5, 7, 9, then one negate clock, then TA_OE=0.
- Region2 EXT, wait 0; EXT_ACK held low 10 clocks then high -> nTA asserted the clock after EXT_ACK is sampled; with TA_TIMEOUT_EN and TIMEOUT_CYCLES=5 with EXT_ACK low -> single nTEA=0, no nTA.
- OVL=1, A=20'h00000 overlaps regions 0 and 3 -> HIT selects OVL_REGION; OVL=0 -> the lowest index wins; unmapped A=20'hFFFFF -> TA_OE never set, BUSY back to 0 after 2 clocks.
- Second nTS during a wait state -> pending flag set, second transfer acknowledged after NEGATE, two acknowledges total; TS_RESET pulsed during WAIT -> TA_OE=0 and all outputs at reset values asynchronously.

Source files
------------

// File: rtl/u409_pkg.sv
// rtl/u409_pkg.sv - shared state encoding, field widths and flag layout for the U409 TA engine
package u409_pkg;
   localparam int ADDR_W = 20;
   localparam int WAIT_W = 4;
   localparam int IDX_W  = 3;

   localparam int FLAG_EXT   = 3;
   localparam int FLAG_TCI   = 2;
   localparam int FLAG_TBI   = 1;
   localparam int FLAG_BURST = 0;

   localparam logic [1:0] SIZ_LINE = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DECODE,
      S_WAIT,
      S_EXTW,
      S_ACK,
      S_NEGATE,
      S_TEA
   } state_t;
endpackage

// File: rtl/u409_region_decode.sv
// rtl/u409_region_decode.sv - priority window decoder with ROM overlay override
module u409_region_decode
   import u409_pkg::*;
#(
   parameter int NUM_REGIONS = 4,
   parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = {NUM_REGIONS{20'h0}},
   parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK = {NUM_REGIONS{20'hFFFFF}},
   parameter int OVL_REGION = 0
) (
   input  logic [ADDR_W-1:0]      addr,
   input  logic                   ovl,
   output logic [NUM_REGIONS-1:0] hit,
   output logic [IDX_W-1:0]       idx,
   output logic                   any
);
   always_comb begin
      hit = '0;
      idx = '0;
      any = 1'b0;
      // Scan downward so the lowest matching index is the last one written.
      for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
         if (((addr ^ REGION_BASE[i*ADDR_W +: ADDR_W]) & REGION_MASK[i*ADDR_W +: ADDR_W]) == '0) begin
            idx = IDX_W'(i);
            any = 1'b1;
         end
      end
      // addr[19:7] is A[31:19]: the overlay only redirects the bottom 512 KB.
      if (any && ovl && addr[ADDR_W-1:7] == '0)
         idx = IDX_W'(OVL_REGION);
      for (int i = 0; i < NUM_REGIONS; i++)
         hit[i] = any && (idx == IDX_W'(i));
   end
endmodule

// File: rtl/u409_ta_engine.sv
// rtl/u409_ta_engine.sv - 68040 transfer-acknowledge engine; TA_TIMEOUT_EN adds the EXT-wait timeout
module u409_ta_engine
   import u409_pkg::*;
#(
   parameter int NUM_REGIONS = 4,
   parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE  = {NUM_REGIONS{20'h0}},
   parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK  = {NUM_REGIONS{20'hFFFFF}},
   parameter logic [NUM_REGIONS*WAIT_W-1:0] REGION_WAIT  = {NUM_REGIONS{4'd2}},
   parameter logic [NUM_REGIONS*4-1:0]      REGION_FLAGS = {NUM_REGIONS{4'b0110}},
   parameter logic [WAIT_W-1:0]             BURST_WAIT   = 4'd1,
   parameter int OVL_REGION     = 0,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                   CLK40,
   input  logic                   TS_RESET,
   input  logic                   nTS,
   input  logic [ADDR_W-1:0]      A,
   input  logic [1:0]             SIZ,
   input  logic                   RnW,
   input  logic                   OVL,
   input  logic                   EXT_ACK,
   output logic                   nTA_OUT,
   output logic                   TA_OE,
   output logic                   nTCI,
   output logic                   nTBI,
   output logic                   nTEA,
   output logic [NUM_REGIONS-1:0] HIT,
   output logic                   BUSY
);
   state_t              state;
   logic [ADDR_W-1:0]   a_lat, a_pend;
   logic [1:0]          siz_lat, siz_pend;
   logic                rnw_lat, rnw_pend, ovl_lat, ovl_pend, pending;
   logic [WAIT_W-1:0]   wcnt;
   logic [1:0]          beat;
   logic [3:0]          flags;
   logic                burst;
   logic [NUM_REGIONS-1:0] dec_hit;
   logic [IDX_W-1:0]    dec_idx;
   logic                dec_any;
   logic [3:0]          sel_flags;
   logic [WAIT_W-1:0]   sel_wait;
   logic                ack_ntci, ack_ntbi;
`ifdef TA_TIMEOUT_EN
   logic [7:0]          tcnt;
   logic                unused_cfg;
   assign unused_cfg = rnw_lat;
`else
   logic                unused_cfg;
   assign unused_cfg = ^{rnw_lat, 8'(TIMEOUT_CYCLES)};
`endif

   u409_region_decode #(
      .NUM_REGIONS (NUM_REGIONS),
      .REGION_BASE (REGION_BASE),
      .REGION_MASK (REGION_MASK),
      .OVL_REGION  (OVL_REGION)
   ) u_decode (
      .addr (a_lat),
      .ovl  (ovl_lat),
      .hit  (dec_hit),
      .idx  (dec_idx),
      .any  (dec_any)
   );

   assign sel_flags = REGION_FLAGS[int'(dec_idx)*4 +: 4];
   assign sel_wait  = REGION_WAIT[int'(dec_idx)*WAIT_W +: WAIT_W];
   assign ack_ntci  = ~flags[FLAG_TCI];
   // A region that cannot burst always reports burst-inhibit.
   assign ack_ntbi  = ~(flags[FLAG_TBI] | ~flags[FLAG_BURST]);
   assign BUSY      = (state != S_IDLE);

   always_ff @(posedge CLK40 or posedge TS_RESET) begin
      if (TS_RESET) begin
         state <= S_IDLE;
         nTA_OUT <= 1'b1; TA_OE <= 1'b0; nTCI <= 1'b1; nTBI <= 1'b1; nTEA <= 1'b1;
         HIT <= '0; wcnt <= '0; beat <= '0; flags <= '0; burst <= 1'b0; pending <= 1'b0;
         a_lat <= '0; siz_lat <= '0; rnw_lat <= 1'b0; ovl_lat <= 1'b0;
         a_pend <= '0; siz_pend <= '0; rnw_pend <= 1'b0; ovl_pend <= 1'b0;
`ifdef TA_TIMEOUT_EN
         tcnt <= '0;
`endif
      end else begin
         nTA_OUT <= 1'b1; TA_OE <= 1'b0; nTCI <= 1'b1; nTBI <= 1'b1; nTEA <= 1'b1;
         // IDLE and NEGATE take a new start directly; elsewhere it is parked once.
         if (!nTS && !pending && state != S_IDLE && state != S_NEGATE) begin
            pending <= 1'b1;
            a_pend <= A; siz_pend <= SIZ; rnw_pend <= RnW; ovl_pend <= OVL;
         end
         case (state)
            S_IDLE, S_NEGATE: begin
               if (state == S_NEGATE) HIT <= '0;
               if (pending) begin
                  a_lat <= a_pend; siz_lat <= siz_pend; rnw_lat <= rnw_pend; ovl_lat <= ovl_pend;
                  pending <= 1'b0;
                  state <= S_DECODE;
               end else if (!nTS) begin
                  a_lat <= A; siz_lat <= SIZ; rnw_lat <= RnW; ovl_lat <= OVL;
                  state <= S_DECODE;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_DECODE: begin
               if (dec_any) begin
                  HIT   <= dec_hit;
                  wcnt  <= sel_wait;
                  flags <= sel_flags;
                  burst <= sel_flags[FLAG_BURST] && !sel_flags[FLAG_TBI] && (siz_lat == SIZ_LINE);
                  beat  <= '0;
                  state <= S_WAIT;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_WAIT: begin
               TA_OE <= (beat != 2'd0);
               if (wcnt != '0) begin
                  wcnt <= wcnt - 1'b1;
               end else if (flags[FLAG_EXT] && beat == 2'd0) begin
`ifdef TA_TIMEOUT_EN
                  tcnt <= '0;
`endif
                  state <= S_EXTW;
               end else begin
                  nTA_OUT <= 1'b0; TA_OE <= 1'b1; nTCI <= ack_ntci; nTBI <= ack_ntbi;
                  state <= S_ACK;
               end
            end
            S_EXTW: begin
               if (EXT_ACK) begin
                  nTA_OUT <= 1'b0; TA_OE <= 1'b1; nTCI <= ack_ntci; nTBI <= ack_ntbi;
                  state <= S_ACK;
               end
`ifdef TA_TIMEOUT_EN
               else if (tcnt == 8'(TIMEOUT_CYCLES - 1)) begin
                  nTEA <= 1'b0; TA_OE <= 1'b1;
                  state <= S_TEA;
               end else begin
                  tcnt <= tcnt + 8'd1;
               end
`endif
            end
            S_ACK: begin
               beat  <= beat + 2'd1;
               TA_OE <= 1'b1;
               if (burst && beat != 2'd3) begin
                  if (BURST_WAIT == '0) begin
                     nTA_OUT <= 1'b0; nTCI <= ack_ntci; nTBI <= ack_ntbi;
                  end else begin
                     wcnt  <= BURST_WAIT - 1'b1;
                     state <= S_WAIT;
                  end
               end else begin
                  state <= S_NEGATE;
               end
            end
            S_TEA: begin
               TA_OE <= 1'b1;
               state <= S_NEGATE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
